// File: rtl/classifier_scheduler_if.sv
// Bus bundle between the feature producers, the BLE snoop tap, the shared
// classifier and the result consumer.
//   src_*    : per-source feature beat streams (16 bits per source, packed)
//   ble_*    : snooped model-load byte stream
//   clf_*    : beat stream towards the classifier and its decision bit
//   result_* : tagged one-cycle result strobe
// slave  : the scheduler side
// master : the surrounding system side
interface classifier_scheduler_if #(
  parameter int unsigned NUM_SOURCES = 4
);
  localparam int unsigned SRC_W = $clog2(NUM_SOURCES);

  logic [16*NUM_SOURCES-1:0] src_data_in;
  logic [NUM_SOURCES-1:0]    src_valid_in;
  logic [NUM_SOURCES-1:0]    src_last_in;
  logic [NUM_SOURCES-1:0]    src_ready_out;

  logic [7:0]                ble_data_in;
  logic                      ble_valid_in;

  logic [15:0]               clf_data_out;
  logic                      clf_valid_out;
  logic                      clf_last_out;
  logic                      clf_predict_enable_out;
  logic                      clf_detected_in;

  logic                      result_valid_out;
  logic [SRC_W-1:0]          result_src_out;
  logic                      result_detected_out;

  modport slave (
    input  src_data_in, src_valid_in, src_last_in,
    input  ble_data_in, ble_valid_in,
    input  clf_detected_in,
    output src_ready_out,
    output clf_data_out, clf_valid_out, clf_last_out, clf_predict_enable_out,
    output result_valid_out, result_src_out, result_detected_out
  );

  modport master (
    output src_data_in, src_valid_in, src_last_in,
    output ble_data_in, ble_valid_in,
    output clf_detected_in,
    input  src_ready_out,
    input  clf_data_out, clf_valid_out, clf_last_out, clf_predict_enable_out,
    input  result_valid_out, result_src_out, result_detected_out
  );
endinterface

// File: rtl/classifier_scheduler.sv
// Shares one linear-SVM classifier between NUM_SOURCES feature producers.
// Snoops the BLE model-load stream to track model residency and support
// vector count, grants the classifier round-robin one packet at a time,
// forwards the packet, waits out the compute latency and reports a tagged
// result.
// Ports:
//   clk_in          : system clock
//   rst_n_in        : synchronous active-low reset
//   bus             : source / BLE / classifier / result bundle (slave side)
//   model_ready_out : a complete model with at least one support vector is loaded
//   busy_out        : scheduler is not idle
module classifier_scheduler #(
  parameter int unsigned NUM_SOURCES  = 4,
  parameter int unsigned NUM_FEATURES = 16,
  parameter int unsigned SLACK        = 8
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  classifier_scheduler_if.slave  bus,
  output logic                   model_ready_out,
  output logic                   busy_out
);

  localparam int unsigned SRC_W  = $clog2(NUM_SOURCES);
  localparam int unsigned BEAT_W = $clog2(NUM_FEATURES + 1);
  localparam int unsigned WAIT_W = $clog2(256 + SLACK);
  localparam int unsigned REM_W  = 17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_WAIT,
    S_REPORT
  } state_e;

  // Model tracker
  logic             loading_q;
  logic [7:0]       num_sv_q;
  logic [REM_W-1:0] rem_q;
  logic             model_ready_q;

  // Main FSM
  state_e              state_q, state_d;
  logic [SRC_W-1:0]    grant_q, grant_d;
  logic [SRC_W-1:0]    ptr_q, ptr_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                err_q, err_d;
  logic                det_q, det_d;
  logic [NUM_SOURCES-1:0] ready_q, ready_d;
  logic [15:0]         clf_data_q, clf_data_d;
  logic                clf_valid_q, clf_valid_d;
  logic                clf_last_q, clf_last_d;
  logic                pred_q, pred_d;
  logic                res_valid_q, res_valid_d;
  logic [SRC_W-1:0]    res_src_q, res_src_d;
  logic                res_det_q, res_det_d;
  logic                busy_q, busy_d;

  logic                hs_c;
  logic                src_last_c;
  logic [15:0]         src_beat_c;
  logic [BEAT_W-1:0]   beat_inc_c;
  logic [WAIT_W-1:0]   wait_load_c;
  logic                arb_ok_c;
  logic                found_c;

  // Model tracker: first byte outside a load is n, then 2*(F-1)*n+4 more bytes follow
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      loading_q     <= 1'b0;
      num_sv_q      <= 8'd0;
      rem_q         <= '0;
      model_ready_q <= 1'b0;
    end else if (bus.ble_valid_in) begin
      if (!loading_q) begin
        loading_q     <= 1'b1;
        num_sv_q      <= bus.ble_data_in;
        model_ready_q <= 1'b0;
        rem_q         <= REM_W'(2 * (NUM_FEATURES - 1)) * REM_W'(bus.ble_data_in) + REM_W'(4);
      end else begin
        rem_q <= rem_q - REM_W'(1);
        if (rem_q == REM_W'(1)) begin
          loading_q     <= 1'b0;
          model_ready_q <= (num_sv_q != 8'd0);
        end
      end
    end
  end

  assign src_beat_c  = bus.src_data_in[{grant_q, 4'd0} +: 16];
  assign src_last_c  = bus.src_last_in[grant_q];
  assign hs_c        = bus.src_valid_in[grant_q] & ready_q[grant_q];
  assign beat_inc_c  = beat_q + BEAT_W'(1);
  assign wait_load_c = WAIT_W'(num_sv_q) + WAIT_W'(SLACK);
  // A load start on this cycle beats arbitration
  assign arb_ok_c    = model_ready_q & ~loading_q & ~bus.ble_valid_in;

  // Main FSM state register
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      ptr_q       <= SRC_W'(NUM_SOURCES - 1);
      beat_q      <= '0;
      wait_q      <= '0;
      err_q       <= 1'b0;
      det_q       <= 1'b0;
      ready_q     <= '0;
      clf_data_q  <= '0;
      clf_valid_q <= 1'b0;
      clf_last_q  <= 1'b0;
      pred_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_src_q   <= '0;
      res_det_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      beat_q      <= beat_d;
      wait_q      <= wait_d;
      err_q       <= err_d;
      det_q       <= det_d;
      ready_q     <= ready_d;
      clf_data_q  <= clf_data_d;
      clf_valid_q <= clf_valid_d;
      clf_last_q  <= clf_last_d;
      pred_q      <= pred_d;
      res_valid_q <= res_valid_d;
      res_src_q   <= res_src_d;
      res_det_q   <= res_det_d;
      busy_q      <= busy_d;
    end
  end

  // Main FSM next state and registered-output values
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    beat_d      = beat_q;
    wait_d      = wait_q;
    err_d       = err_q;
    det_d       = det_q;
    clf_data_d  = '0;
    clf_valid_d = 1'b0;
    clf_last_d  = 1'b0;
    res_valid_d = 1'b0;
    res_src_d   = '0;
    res_det_d   = 1'b0;
    found_c     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (arb_ok_c) begin
          // Walk from farthest to nearest so the nearest requester after ptr wins
          for (int i = int'(NUM_SOURCES); i >= 1; i--) begin
            if (bus.src_valid_in[SRC_W'((int'(ptr_q) + i) % int'(NUM_SOURCES))]) begin
              grant_d = SRC_W'((int'(ptr_q) + i) % int'(NUM_SOURCES));
              found_c = 1'b1;
            end
          end
          if (found_c) begin
            beat_d  = '0;
            state_d = S_STREAM;
          end
        end
      end

      S_STREAM: begin
        if (hs_c) begin
          clf_valid_d = 1'b1;
          clf_data_d  = src_beat_c;
          beat_d      = beat_inc_c;
          clf_last_d  = src_last_c | (beat_inc_c == BEAT_W'(NUM_FEATURES));
          if (src_last_c) begin
            if (beat_inc_c != BEAT_W'(NUM_FEATURES)) err_d = 1'b1;
            wait_d  = wait_load_c;
            state_d = S_WAIT;
          end else if (beat_inc_c == BEAT_W'(NUM_FEATURES)) begin
            // Classifier already has a full frame; swallow the overrun
            err_d   = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end

      S_DRAIN: begin
        if (hs_c && src_last_c) begin
          wait_d  = wait_load_c;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (wait_q == '0) begin
          det_d   = bus.clf_detected_in;
          state_d = S_REPORT;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end

      S_REPORT: begin
        res_valid_d = ~err_q;
        res_src_d   = err_q ? '0 : grant_q;
        res_det_d   = ~err_q & det_q;
        ptr_d       = grant_q;
        err_d       = 1'b0;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // A model reload mid-packet invalidates the result but the frame still completes
    if (bus.ble_valid_in && (state_q inside {S_STREAM, S_DRAIN, S_WAIT})) err_d = 1'b1;

    ready_d = '0;
    if (state_d == S_STREAM || state_d == S_DRAIN) ready_d[grant_d] = 1'b1;
    busy_d  = (state_d != S_IDLE);
    // Cover every STREAM cycle plus the cycle carrying the final forwarded beat
    pred_d  = (state_d == S_STREAM) || (state_q == S_STREAM);
  end

  assign bus.src_ready_out          = ready_q;
  assign bus.clf_data_out           = clf_data_q;
  assign bus.clf_valid_out          = clf_valid_q;
  assign bus.clf_last_out           = clf_last_q;
  assign bus.clf_predict_enable_out = pred_q;
  assign bus.result_valid_out       = res_valid_q;
  assign bus.result_src_out         = res_src_q;
  assign bus.result_detected_out    = res_det_q;
  assign model_ready_out            = model_ready_q;
  assign busy_out                   = busy_q;

endmodule

// File: tb/tb_classifier_scheduler.sv
// Directed self-checking bench for classifier_scheduler: model loading,
// single-source forwarding and latency, round-robin, short/long packets and
// a model reload landing while the classifier is computing.
module tb_classifier_scheduler;

  localparam int unsigned NS    = 4;
  localparam int unsigned NF    = 16;
  localparam int unsigned SLACK = 8;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  logic model_ready_out;
  logic busy_out;

  always #5 clk_in = ~clk_in;

  classifier_scheduler_if #(.NUM_SOURCES(NS)) bus ();

  classifier_scheduler #(
    .NUM_SOURCES (NS),
    .NUM_FEATURES(NF),
    .SLACK       (SLACK)
  ) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .bus            (bus),
    .model_ready_out(model_ready_out),
    .busy_out       (busy_out)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int len  [NS];
  int idx  [NS];
  int npkt [NS];
  int grants[$];
  int res_src[$];
  int res_det[$];
  int res_cyc[$];
  int last_fwd_cyc;
  int drain_cnt;
  int rr_exp [5] = '{0, 1, 2, 3, 0};

  logic       ble_v;
  logic [7:0] ble_d;
  logic       det_drive;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] beat_val(input int s, input int k);
    return 16'(s * 4096 + k * 37 + 5);
  endfunction

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic logic all_done();
    for (int s = 0; s < int'(NS); s++) if (len[s] != 0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: drive sources/BLE, advance, then score handshakes and results
  task automatic step();
    logic [NS-1:0]    vld, lst, rdy, hs;
    logic [16*NS-1:0] dat;
    vld = '0;
    lst = '0;
    dat = '0;
    for (int s = 0; s < int'(NS); s++) begin
      if (len[s] > 0) begin
        vld[s] = 1'b1;
        lst[s] = (idx[s] == len[s] - 1);
        dat[16*s +: 16] = beat_val(s, idx[s]);
      end
    end
    bus.src_valid_in    = vld;
    bus.src_last_in     = lst;
    bus.src_data_in     = dat;
    bus.ble_valid_in    = ble_v;
    bus.ble_data_in     = ble_d;
    bus.clf_detected_in = det_drive;
    rdy = bus.src_ready_out;
    @(posedge clk_in);
    #1;
    hs = rdy & vld;
    if (hs != '0) chk("ready_onehot", 32'($countones(rdy)), 32'd1);
    for (int s = 0; s < int'(NS); s++) begin
      if (hs[s]) begin
        if (idx[s] == 0) grants.push_back(s);
        if (idx[s] < int'(NF)) begin
          chk("fwd_valid", 32'(bus.clf_valid_out), 32'd1);
          chk("fwd_data", 32'(bus.clf_data_out), 32'(beat_val(s, idx[s])));
          chk("fwd_last", 32'(bus.clf_last_out),
              32'((idx[s] == len[s] - 1) || (idx[s] == int'(NF) - 1)));
          chk("fwd_predict", 32'(bus.clf_predict_enable_out), 32'd1);
          last_fwd_cyc = cyc;
        end else begin
          chk("drain_quiet", 32'(bus.clf_valid_out), 32'd0);
          drain_cnt++;
        end
        idx[s]++;
        if (idx[s] == len[s]) begin
          idx[s] = 0;
          if (npkt[s] > 0) npkt[s]--;
          else len[s] = 0;
        end
      end
    end
    if (bus.result_valid_out) begin
      res_src.push_back(int'(bus.result_src_out));
      res_det.push_back(int'(bus.result_detected_out));
      res_cyc.push_back(cyc);
    end
  endtask

  task automatic run_idle(input int budget);
    int   n;
    logic pend;
    n    = 0;
    pend = 1'b1;
    while (pend && n < budget) begin
      step();
      n++;
      pend = busy_out || !all_done();
    end
    chk("run_timeout", 32'(pend), 32'd0);
    repeat (3) step();
  endtask

  task automatic load_model(input int n, input logic exp_ready);
    int total;
    total = 1 + 2 * (int'(NF) - 1) * n + 4;
    for (int b = 0; b < total; b++) begin
      ble_v = 1'b1;
      ble_d = (b == 0) ? 8'(n) : 8'(b);
      step();
      if (b == 0) chk("load_start_drop", 32'(model_ready_out), 32'd0);
      if (b == total - 2) chk("load_not_early", 32'(model_ready_out), 32'd0);
    end
    ble_v = 1'b0;
    chk("load_ready", 32'(model_ready_out), 32'(exp_ready));
  endtask

  task automatic clear_logs();
    grants.delete();
    res_src.delete();
    res_det.delete();
    res_cyc.delete();
    drain_cnt = 0;
  endtask

  initial begin
    int n;
    foreach (len[s]) begin
      len[s]  = 0;
      idx[s]  = 0;
      npkt[s] = 0;
    end
    ble_v        = 1'b0;
    ble_d        = 8'd0;
    det_drive    = 1'b0;
    last_fwd_cyc = 0;
    drain_cnt    = 0;

    // Reset state
    rst_n_in = 1'b0;
    @(posedge clk_in);
    #1;
    step();
    step();
    chk("rst_ready", 32'(bus.src_ready_out), 32'd0);
    chk("rst_clf_valid", 32'(bus.clf_valid_out), 32'd0);
    chk("rst_clf_data", 32'(bus.clf_data_out), 32'd0);
    chk("rst_clf_last", 32'(bus.clf_last_out), 32'd0);
    chk("rst_clf_pred", 32'(bus.clf_predict_enable_out), 32'd0);
    chk("rst_res_valid", 32'(bus.result_valid_out), 32'd0);
    chk("rst_res_src", 32'(bus.result_src_out), 32'd0);
    chk("rst_res_det", 32'(bus.result_detected_out), 32'd0);
    chk("rst_model_ready", 32'(model_ready_out), 32'd0);
    chk("rst_busy", 32'(busy_out), 32'd0);
    rst_n_in = 1'b1;

    // No model: a requester is never granted
    len[0] = 16;
    repeat (5) step();
    chk("nomodel_busy", 32'(busy_out), 32'd0);
    chk("nomodel_ready", 32'(bus.src_ready_out), 32'd0);
    len[0] = 0;

    // Model loads: n=0 stays not-ready, n=3 (95 bytes), then n=2 for traffic
    load_model(0, 1'b0);
    load_model(3, 1'b1);
    load_model(2, 1'b1);

    // Single source 2, full packet; result 2+8+2 cycles after last forwarded beat
    clear_logs();
    det_drive = 1'b1;
    len[2] = 16;
    run_idle(200);
    chk("single_grants", 32'(grants.size()), 32'd1);
    chk("single_grant_src", 32'(q_at(grants, 0)), 32'd2);
    chk("single_res_count", 32'(res_src.size()), 32'd1);
    chk("single_res_src", 32'(q_at(res_src, 0)), 32'd2);
    chk("single_res_det", 32'(q_at(res_det, 0)), 32'd1);
    chk("single_latency", 32'(q_at(res_cyc, 0) - last_fwd_cyc), 32'd12);
    chk("single_idle", 32'(busy_out), 32'd0);

    // Short packet on source 3: last on beat 10, result suppressed
    clear_logs();
    det_drive = 1'b0;
    len[3] = 10;
    run_idle(200);
    chk("short_grant_src", 32'(q_at(grants, 0)), 32'd3);
    chk("short_no_result", 32'(res_src.size()), 32'd0);

    // Round-robin with all sources requesting, source 0 has a second packet
    clear_logs();
    for (int s = 0; s < int'(NS); s++) len[s] = 16;
    npkt[0] = 1;
    run_idle(600);
    chk("rr_grants", 32'(grants.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("rr_grant", 32'(q_at(grants, i)), 32'(rr_exp[i]));
      chk("rr_res_src", 32'(q_at(res_src, i)), 32'(rr_exp[i]));
    end
    chk("rr_res_det", 32'(q_at(res_det, 4)), 32'd0);

    // Long packet on source 1: 16 forwarded, 4 drained, no result
    clear_logs();
    len[1] = 20;
    run_idle(200);
    chk("long_grant_src", 32'(q_at(grants, 0)), 32'd1);
    chk("long_drained", 32'(drain_cnt), 32'd4);
    chk("long_no_result", 32'(res_src.size()), 32'd0);

    // Model reload starting while source 0 waits on the classifier
    clear_logs();
    det_drive = 1'b1;
    len[0] = 16;
    n = 0;
    while (len[0] != 0 && n < 100) begin
      step();
      n++;
    end
    chk("ble_pkt_sent", 32'(len[0]), 32'd0);
    step();
    step();
    chk("ble_busy_in_wait", 32'(busy_out), 32'd1);
    len[2] = 16;
    load_model(1, 1'b1);
    chk("ble_no_grant_in_load", 32'(grants.size()), 32'd1);
    chk("ble_suppressed", 32'(res_src.size()), 32'd0);
    run_idle(200);
    chk("ble_next_grant", 32'(q_at(grants, 1)), 32'd2);
    chk("ble_res_count", 32'(res_src.size()), 32'd1);
    chk("ble_res_src", 32'(q_at(res_src, 0)), 32'd2);
    chk("ble_res_det", 32'(q_at(res_det, 0)), 32'd1);
    chk("ble_latency", 32'(q_at(res_cyc, 0) - last_fwd_cyc), 32'd11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached after %0d checks", n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
